// File: rtl/l2_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module  : l2_ctrl_regs
// Brief   : L2 controller state-register bank. It holds the generic flags, the
//           set/way flush walker, the free request-slot counter and the
//           forward-stall trackers.
// Revision: 1.0 - initial release
// ============================================================================
module l2_ctrl_regs #(
    parameter int SET_BITS = 8,
    parameter int WAY_BITS = 3,
    parameter int N_REQS   = 4,
    parameter int N_STALL  = 2,
    parameter int N_FLAGS  = 4,
    localparam int RB = (N_REQS > 1) ? $clog2(N_REQS) : 1,
    localparam int CB = $clog2(N_REQS + 1),
    localparam int SB = (N_STALL > 1) ? $clog2(N_STALL) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_FLAGS-1:0]    flag_set,
    input  logic [N_FLAGS-1:0]    flag_clr,
    output logic [N_FLAGS-1:0]    flags,
    input  logic                  flush_start,
    input  logic                  flush_step,
    input  logic                  flush_abort,
    output logic                  ongoing_flush,
    output logic [SET_BITS-1:0]   flush_set,
    output logic [WAY_BITS-1:0]   flush_way,
    output logic                  flush_done,
    input  logic                  req_alloc,
    input  logic                  req_free,
    output logic [CB-1:0]         reqs_cnt,
    output logic                  reqs_empty_slots,
    output logic                  reqs_err,
    input  logic                  err_clr,
    input  logic                  stall_set,
    input  logic [SB-1:0]         stall_ch,
    input  logic [RB-1:0]         stall_idx,
    input  logic [N_STALL-1:0]    stall_clr,
    input  logic [N_STALL-1:0]    ended_clr,
    input  logic                  wr_en_put_reqs,
    input  logic [RB-1:0]         reqs_i,
    input  logic                  put_reqs_atomic,
    input  logic [RB-1:0]         reqs_atomic_i,
    output logic [N_STALL-1:0]    stall_valid,
    output logic [N_STALL*RB-1:0] stall_idx_q,
    output logic [N_STALL-1:0]    stall_ended
);

    localparam logic [SET_BITS-1:0] c_set_last = '1;
    localparam logic [WAY_BITS-1:0] c_way_last = '1;
    localparam logic [CB-1:0]       c_cnt_full = CB'(N_REQS);

    logic [N_FLAGS-1:0]  r_flags;
    logic                r_ongoing;
    logic [SET_BITS-1:0] r_set;
    logic [WAY_BITS-1:0] r_way;
    logic                r_done;
    logic [CB-1:0]       r_cnt;
    logic                r_err;

    logic w_alloc_only;
    logic w_free_only;
    logic w_underflow;
    logic w_overflow;

    // Clear wins over set on a per-bit basis.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flags <= '0;
        end else begin
            r_flags <= (r_flags | flag_set) & ~flag_clr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ongoing <= 1'b0;
            r_set     <= '0;
            r_way     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (flush_abort) begin
                r_ongoing <= 1'b0;
                r_set     <= '0;
                r_way     <= '0;
            end else if (flush_start && !r_ongoing) begin
                r_ongoing <= 1'b1;
                r_set     <= '0;
                r_way     <= '0;
            end else if (flush_step && r_ongoing) begin
                if (r_way != c_way_last) begin
                    r_way <= r_way + 1'b1;
                end else begin
                    r_way <= '0;
                    if (r_set == c_set_last) begin
                        r_ongoing <= 1'b0;
                        r_set     <= '0;
                        r_done    <= 1'b1;
                    end else begin
                        r_set <= r_set + 1'b1;
                    end
                end
            end
        end
    end

    assign w_alloc_only = req_alloc && !req_free;
    assign w_free_only  = req_free && !req_alloc;
    assign w_underflow  = w_alloc_only && (r_cnt == '0);
    assign w_overflow   = w_free_only && (r_cnt == c_cnt_full);

    // An illegal request holds the count; a fresh error beats err_clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= c_cnt_full;
            r_err <= 1'b0;
        end else begin
            if (w_alloc_only && !w_underflow) begin
                r_cnt <= r_cnt - 1'b1;
            end else if (w_free_only && !w_overflow) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_underflow || w_overflow) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < N_STALL; k++) begin : g_stall
        logic          r_valid;
        logic          r_ended;
        logic [RB-1:0] r_idx;
        logic          w_arm;
        logic          w_match;

        assign w_arm   = stall_set && (32'(stall_ch) == k);
        assign w_match = r_valid && wr_en_put_reqs &&
                         ((r_idx == reqs_i) ||
                          (put_reqs_atomic && (r_idx == reqs_atomic_i)));

        // Re-arming overrides any clear or completion seen in the same cycle.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_valid <= 1'b0;
                r_ended <= 1'b0;
                r_idx   <= '0;
            end else if (w_arm) begin
                r_valid <= 1'b1;
                r_ended <= 1'b0;
                r_idx   <= stall_idx;
            end else begin
                if (stall_clr[k]) begin
                    r_valid <= 1'b0;
                end
                if (ended_clr[k]) begin
                    r_ended <= 1'b0;
                end else if (w_match) begin
                    r_ended <= 1'b1;
                end
            end
        end

        assign stall_valid[k]          = r_valid;
        assign stall_ended[k]          = r_ended;
        assign stall_idx_q[k*RB +: RB] = r_idx;
    end

    assign flags            = r_flags;
    assign ongoing_flush    = r_ongoing;
    assign flush_set        = r_set;
    assign flush_way        = r_way;
    assign flush_done       = r_done;
    assign reqs_cnt         = r_cnt;
    assign reqs_empty_slots = (r_cnt == '0);
    assign reqs_err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_l2_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module  : tb_l2_ctrl_regs
// Brief   : Self-checking bench for l2_ctrl_regs with a small 4-set, 2-way cache.
// Revision: 1.0 - initial release
// ============================================================================
module tb_l2_ctrl_regs;

    localparam int SET_BITS = 2;
    localparam int WAY_BITS = 1;
    localparam int N_REQS   = 4;
    localparam int N_STALL  = 2;
    localparam int N_FLAGS  = 4;

    logic       clk;
    logic       rst;
    logic [3:0] flag_set, flag_clr, flags;
    logic       flush_start, flush_step, flush_abort;
    logic       ongoing_flush, flush_done;
    logic [1:0] flush_set;
    logic [0:0] flush_way;
    logic       req_alloc, req_free, reqs_empty_slots, reqs_err, err_clr;
    logic [2:0] reqs_cnt;
    logic       stall_set;
    logic [0:0] stall_ch;
    logic [1:0] stall_idx;
    logic [1:0] stall_clr, ended_clr;
    logic       wr_en_put_reqs, put_reqs_atomic;
    logic [1:0] reqs_i, reqs_atomic_i;
    logic [1:0] stall_valid, stall_ended;
    logic [3:0] stall_idx_q;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb_q[$];
    logic [31:0] e;

    l2_ctrl_regs #(
        .SET_BITS(SET_BITS), .WAY_BITS(WAY_BITS), .N_REQS(N_REQS),
        .N_STALL(N_STALL), .N_FLAGS(N_FLAGS)
    ) dut (
        .clk(clk), .rst(rst),
        .flag_set(flag_set), .flag_clr(flag_clr), .flags(flags),
        .flush_start(flush_start), .flush_step(flush_step), .flush_abort(flush_abort),
        .ongoing_flush(ongoing_flush), .flush_set(flush_set), .flush_way(flush_way),
        .flush_done(flush_done),
        .req_alloc(req_alloc), .req_free(req_free), .reqs_cnt(reqs_cnt),
        .reqs_empty_slots(reqs_empty_slots), .reqs_err(reqs_err), .err_clr(err_clr),
        .stall_set(stall_set), .stall_ch(stall_ch), .stall_idx(stall_idx),
        .stall_clr(stall_clr), .ended_clr(ended_clr),
        .wr_en_put_reqs(wr_en_put_reqs), .reqs_i(reqs_i),
        .put_reqs_atomic(put_reqs_atomic), .reqs_atomic_i(reqs_atomic_i),
        .stall_valid(stall_valid), .stall_idx_q(stall_idx_q), .stall_ended(stall_ended)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flag_set = '0; flag_clr = '0;
        flush_start = 0; flush_step = 0; flush_abort = 0;
        req_alloc = 0; req_free = 0; err_clr = 0;
        stall_set = 0; stall_ch = '0; stall_idx = '0;
        stall_clr = '0; ended_clr = '0;
        wr_en_put_reqs = 0; reqs_i = '0; put_reqs_atomic = 0; reqs_atomic_i = '0;
    endtask

    // Snapshot of every output: {flags,ongoing,set,way,done,cnt,empty,err,valid,idx_q,ended}
    function automatic logic [31:0] outs();
        return {10'd0, flags, ongoing_flush, flush_set, flush_way, flush_done,
                reqs_cnt, reqs_empty_slots, reqs_err, stall_valid, stall_idx_q, stall_ended};
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        sb_q.push_back({10'd0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0});
        repeat (3) tick();
        rst = 1'b1;
        tick();
        e = sb_q.pop_front(); total++;
        if (outs() !== e) begin
            bad++; $display("FAIL reset_state got=%h want=%h", outs(), e);
        end
    endtask

    task automatic test_flush_walk();
        flush_start = 1; sb_q.push_back(32'd0);
        tick(); flush_start = 0;
        for (int i = 0; i < 8; i++) begin
            e = sb_q.pop_front(); total++;
            if ({ongoing_flush, flush_done, flush_set, flush_way} !== {2'b10, e[2:0]}) begin
                bad++; $display("FAIL walk_pos%0d got=%b%b set=%0d way=%0d want=%0d",
                                i, ongoing_flush, flush_done, flush_set, flush_way, e[2:0]);
            end
            flush_step = 1;
            if (i < 7) sb_q.push_back(32'(i + 1));
            tick(); flush_step = 0;
        end
        e = 32'b01_000; total++;
        if ({ongoing_flush, flush_done, flush_set, flush_way} !== e[4:0]) begin
            bad++; $display("FAIL walk_done got=%b%b%0d%0d want=%b",
                            ongoing_flush, flush_done, flush_set, flush_way, e[4:0]);
        end
        tick(); total++;
        if (flush_done !== 1'b0) begin
            bad++; $display("FAIL walk_done_pulse got=%b want=0", flush_done);
        end
    endtask

    task automatic test_flush_abort();
        flush_start = 1; tick(); flush_start = 0;
        flush_step = 1; repeat (3) tick(); flush_step = 0;
        total++;
        if ({ongoing_flush, flush_set, flush_way} !== 4'b1_01_1) begin
            bad++; $display("FAIL abort_pre got=%b%0d%0d want=1,1,1", ongoing_flush, flush_set, flush_way);
        end
        flush_abort = 1; sb_q.push_back(32'd0);
        tick(); flush_abort = 0;
        e = sb_q.pop_front(); total++;
        if ({ongoing_flush, flush_done, flush_set, flush_way} !== e[4:0]) begin
            bad++; $display("FAIL abort_state got=%b%b%0d%0d want=0", ongoing_flush, flush_done, flush_set, flush_way);
        end
        tick(); total++;
        if (flush_done !== 1'b0) begin
            bad++; $display("FAIL abort_no_done got=%b want=0", flush_done);
        end
        flush_start = 1; flush_abort = 1; tick(); flush_start = 0; flush_abort = 0;
        total++;
        if ({ongoing_flush, flush_done} !== 2'b00) begin
            bad++; $display("FAIL start_abort_idle got=%b%b want=00", ongoing_flush, flush_done);
        end
    endtask

    task automatic test_req_counter();
        for (int i = 0; i < 4; i++) begin
            req_alloc = 1; sb_q.push_back(32'(3 - i));
            tick(); req_alloc = 0;
            e = sb_q.pop_front(); total++;
            if (reqs_cnt !== e[2:0] || reqs_err !== 1'b0) begin
                bad++; $display("FAIL alloc%0d cnt=%0d err=%b want=%0d,0", i, reqs_cnt, reqs_err, e[2:0]);
            end
        end
        total++;
        if (reqs_empty_slots !== 1'b1) begin
            bad++; $display("FAIL empty got=%b want=1", reqs_empty_slots);
        end
        req_alloc = 1; tick(); req_alloc = 0; total++;
        if ({reqs_cnt, reqs_err} !== 4'b000_1) begin
            bad++; $display("FAIL underflow cnt=%0d err=%b want=0,1", reqs_cnt, reqs_err);
        end
        req_alloc = 1; req_free = 1; tick(); req_alloc = 0; req_free = 0; total++;
        if ({reqs_cnt, reqs_err} !== 4'b000_1) begin
            bad++; $display("FAIL alloc_free cnt=%0d err=%b want=0,1", reqs_cnt, reqs_err);
        end
        err_clr = 1; tick(); err_clr = 0; total++;
        if (reqs_err !== 1'b0) begin
            bad++; $display("FAIL err_clr got=%b want=0", reqs_err);
        end
        req_free = 1; repeat (4) tick(); total++;
        if ({reqs_cnt, reqs_err, reqs_empty_slots} !== 5'b100_0_0) begin
            bad++; $display("FAIL refill cnt=%0d err=%b want=4,0", reqs_cnt, reqs_err);
        end
        err_clr = 1; tick(); req_free = 0; err_clr = 0; total++;
        if ({reqs_cnt, reqs_err} !== 4'b100_1) begin
            bad++; $display("FAIL overflow_beats_clr cnt=%0d err=%b want=4,1", reqs_cnt, reqs_err);
        end
        err_clr = 1; tick(); err_clr = 0;
    endtask

    task automatic test_stall();
        stall_set = 1; stall_ch = 1'b0; stall_idx = 2'd2; tick();
        stall_ch = 1'b1; stall_idx = 2'd3; tick(); stall_set = 0;
        total++;
        if ({stall_valid, stall_idx_q, stall_ended} !== 8'b11_1110_00) begin
            bad++; $display("FAIL arm valid=%b idx=%b ended=%b want=11,1110,00", stall_valid, stall_idx_q, stall_ended);
        end
        wr_en_put_reqs = 1; reqs_i = 2'd2; sb_q.push_back(32'b01);
        tick(); wr_en_put_reqs = 0;
        e = sb_q.pop_front(); total++;
        if (stall_ended !== e[1:0]) begin
            bad++; $display("FAIL match_plain got=%b want=%b", stall_ended, e[1:0]);
        end
        wr_en_put_reqs = 1; reqs_i = 2'd1; put_reqs_atomic = 1; reqs_atomic_i = 2'd3;
        sb_q.push_back(32'b11);
        tick(); wr_en_put_reqs = 0; put_reqs_atomic = 0;
        e = sb_q.pop_front(); total++;
        if (stall_ended !== e[1:0]) begin
            bad++; $display("FAIL match_atomic got=%b want=%b", stall_ended, e[1:0]);
        end
        ended_clr = 2'b01; wr_en_put_reqs = 1; reqs_i = 2'd2; sb_q.push_back(32'b10);
        tick(); ended_clr = '0; wr_en_put_reqs = 0;
        e = sb_q.pop_front(); total++;
        if (stall_ended !== e[1:0]) begin
            bad++; $display("FAIL clr_beats_match got=%b want=%b", stall_ended, e[1:0]);
        end
        stall_set = 1; stall_ch = 1'b0; stall_idx = 2'd2; wr_en_put_reqs = 1; reqs_i = 2'd2;
        stall_clr = 2'b01; sb_q.push_back(32'b11_10);
        tick(); stall_set = 0; wr_en_put_reqs = 0; stall_clr = '0;
        e = sb_q.pop_front(); total++;
        if ({stall_valid, stall_ended} !== e[3:0]) begin
            bad++; $display("FAIL set_overrides valid=%b ended=%b want=%b", stall_valid, stall_ended, e[3:0]);
        end
        stall_clr = 2'b10; tick(); stall_clr = '0; total++;
        if ({stall_valid, stall_ended} !== 4'b01_10) begin
            bad++; $display("FAIL stall_clr_keeps_ended valid=%b ended=%b want=01,10", stall_valid, stall_ended);
        end
        wr_en_put_reqs = 1; reqs_i = 2'd3; tick(); wr_en_put_reqs = 0;
        ended_clr = 2'b11; tick(); ended_clr = '0; total++;
        if ({stall_valid, stall_ended} !== 4'b01_00) begin
            bad++; $display("FAIL disarmed_no_match valid=%b ended=%b want=01,00", stall_valid, stall_ended);
        end
    endtask

    task automatic test_flags();
        flag_set = 4'b0101; flag_clr = 4'b0100; sb_q.push_back(32'b0001);
        tick(); flag_set = '0; flag_clr = '0;
        e = sb_q.pop_front(); total++;
        if (flags !== e[3:0]) begin
            bad++; $display("FAIL flags_prio got=%b want=%b", flags, e[3:0]);
        end
        flag_set = 4'b1010; sb_q.push_back(32'b1011);
        tick(); flag_set = '0;
        e = sb_q.pop_front(); total++;
        if (flags !== e[3:0]) begin
            bad++; $display("FAIL flags_accum got=%b want=%b", flags, e[3:0]);
        end
    endtask

    task automatic test_async_reset();
        flush_start = 1; tick(); flush_start = 0;
        flush_step = 1; repeat (2) tick(); flush_step = 0;
        stall_set = 1; stall_ch = 1'b1; stall_idx = 2'd1; req_alloc = 1; flag_set = 4'b1111;
        tick();
        stall_set = 0; req_alloc = 0; flag_set = '0;
        total++;
        if ({ongoing_flush, reqs_cnt, flags} !== 8'b1_011_1111) begin
            bad++; $display("FAIL pre_reset ongoing=%b cnt=%0d flags=%b want=1,3,1111", ongoing_flush, reqs_cnt, flags);
        end
        sb_q.push_back({10'd0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0});
        #2 rst = 1'b0;
        #1;
        e = sb_q.pop_front(); total++;
        if (outs() !== e) begin
            bad++; $display("FAIL async_reset got=%h want=%h", outs(), e);
        end
        tick(); total++;
        if (outs() !== e) begin
            bad++; $display("FAIL reset_held got=%h want=%h", outs(), e);
        end
        #2 rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_flush_walk();
        test_flush_abort();
        test_req_counter();
        test_stall();
        test_flags();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
